// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush beats push and pop.
module fetch_fifo import fetch_pkg::*; #(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   input  logic          flush,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);
   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk)
      if (do_push && !flush) mem[wr_ptr] <= push_data;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, imem request issue, in-flight tracking, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN adds fetch_fault and halts on misaligned redirects.
module instr_fetch import fetch_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
   parameter int              FIFO_DEPTH      = 2,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            pcsrc,
   input  logic [XLEN-1:0] pc_target,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic            fetch_fault,
`endif
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            instr_valid,
   input  logic            instr_ready
);
   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int FCW = $clog2(FIFO_DEPTH + 1);

   logic [XLEN-1:0] fetch_pc, resp_pc, pc_last, tgt_aligned;
   logic [CW-1:0]   outstanding, drop_cnt;
   logic [FCW-1:0]  fifo_count;
   logic            fifo_full, fifo_empty, halted;
   logic            rsp_ok, req_fire, push, pop;
   fetch_entry_t    head;

`ifdef FETCH_MISALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     fetch_fault <= 1'b0;
      else if (pcsrc) fetch_fault <= |pc_target[1:0];
   end
   assign halted = fetch_fault;
`else
   logic unused_tgt_lsb;
   assign unused_tgt_lsb = ^pc_target[1:0];
   assign halted         = 1'b0;
`endif

   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_ok      = imem_rsp_valid && (outstanding != '0);
   assign tgt_aligned = {pc_target[XLEN-1:2], 2'b00};

   // Buffer slots are reserved at issue time, so the FIFO can never overflow.
   assign imem_req_valid = rst_n && !pcsrc && !halted && !fifo_full
                        && (32'(outstanding) < 32'(MAX_OUTSTANDING))
                        && ((32'(fifo_count) + 32'(outstanding)) < 32'(FIFO_DEPTH));
   assign imem_addr = fetch_pc;
   assign req_fire  = imem_req_valid && imem_req_ready;

   assign push = rsp_ok && (drop_cnt == '0) && !pcsrc;
   assign pop  = instr_valid && instr_ready && !pcsrc;

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ('{pc: resp_pc, instr: imem_rsp_data}),
      .pop       (pop),
      .flush     (pcsrc),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (head)
   );

   assign instr_valid = !fifo_empty;
   assign instr       = fifo_empty ? NOP_INSTR : head.instr;
   assign pc          = fifo_empty ? pc_last : head.pc;
   assign pc_plus4    = pc + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         pc_last     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
         if (!fifo_empty) pc_last <= head.pc;
         if (pcsrc) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc <= tgt_aligned;
            resp_pc  <= tgt_aligned;
            drop_cnt <= outstanding - CW'(rsp_ok);
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (push)     resp_pc  <= resp_pc + 32'd4;
            if (rsp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench: latency-modelled imem plus an in-order expected-PC stream model.
module tb_instr_fetch;
   import fetch_pkg::*;

   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid, imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        pcsrc = 1'b0;
   logic [31:0] pc_target = '0;
   logic [31:0] instr, pc, pc_plus4;
   logic        instr_valid, instr_ready = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fetch_fault;
`endif

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .pcsrc(pcsrc), .pc_target(pc_target),
`ifdef FETCH_MISALIGN_CHECK_EN
      .fetch_fault(fetch_fault),
`endif
      .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
      .instr_valid(instr_valid), .instr_ready(instr_ready)
   );

   int          checks = 0, errors = 0, cyc = 0;
   int          lat = 1, rdy_pct = 100, ir_pct = 100, inflight = 0, npop = 0;
   logic [31:0] q_addr[$];
   int          q_due[$];
   logic [31:0] exp_pc = 32'h0, exp_req = 32'h0;
   logic        last_valid, last_req_valid;
   logic [31:0] last_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5a3c_0f96;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle, entered and left just after a falling edge.
   task automatic cycle(input logic redir, input logic [31:0] tgt);
      logic fire, rsp, popd;
      pcsrc          = redir;
      pc_target      = tgt;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      instr_ready    = ($urandom_range(99) < ir_pct);
      rsp = (q_addr.size() > 0) && (q_due[0] <= cyc);
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? mem_word(q_addr[0]) : $urandom;
      if (rsp) begin
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end
      #1;
      if (instr_valid) begin
         chk("head_pc", pc, exp_pc);
         chk("head_instr", instr, mem_word(exp_pc));
         chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
      end else begin
         chk("empty_nop", instr, NOP_INSTR);
      end
      if (redir) chk("no_req_on_redirect", {31'h0, imem_req_valid}, 32'h0);
      fire = imem_req_valid && imem_req_ready;
      if (fire) begin
         chk("req_addr", imem_addr, exp_req);
         chk("inflight_bound", {31'h0, inflight < MAXO}, 32'h1);
         q_addr.push_back(imem_addr);
         q_due.push_back(cyc + lat);
      end
      last_valid = instr_valid;
      last_pc = pc;
      last_req_valid = imem_req_valid;
      popd = instr_valid && instr_ready && !redir;
      if (redir) begin
         exp_pc  = {tgt[31:2], 2'b00};
         exp_req = {tgt[31:2], 2'b00};
      end else begin
         if (popd) begin exp_pc = exp_pc + 32'd4; npop++; end
         if (fire) exp_req = exp_req + 32'd4;
      end
      inflight = inflight + (fire ? 1 : 0) - (rsp ? 1 : 0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
   endtask

   initial begin
      int p0;
      logic [31:0] t;
      // Reset state.
      #3;
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_instr", instr, NOP_INSTR);
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc_plus4", pc_plus4, 32'h4);
      chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Zero-wait memory, decode always ready: stream 0,4,8,...
      run(20);
      chk("stream_progress", {31'h0, npop >= 8}, 32'h1);

      // Decode stalls: buffer fills, issue stops, nothing lost afterwards.
      ir_pct = 0;
      run(5);
      chk("stall_full_valid", {31'h0, last_valid}, 32'h1);
      chk("stall_req_valid", {31'h0, last_req_valid}, 32'h0);
      ir_pct = 100;
      run(10);

      // Redirect latency with zero-wait memory: valid at N+3.
      cycle(1'b1, 32'h0000_0300);
      cycle(1'b0, 32'h0);
      chk("redir_n1_valid", {31'h0, last_valid}, 32'h0);
      cycle(1'b0, 32'h0);
      chk("redir_n2_valid", {31'h0, last_valid}, 32'h0);
      cycle(1'b0, 32'h0);
      chk("redir_n3_valid", {31'h0, last_valid}, 32'h1);
      chk("redir_n3_pc", last_pc, 32'h0000_0300);

      // Redirect with two requests in flight on a 3-cycle memory.
      lat = 3;
      begin
         int k = 0;
         while (inflight != 2 && k < 50) begin cycle(1'b0, 32'h0); k++; end
         chk("wait_inflight2", {31'h0, inflight == 2}, 32'h1);
      end
      cycle(1'b1, 32'h0000_0100);
      run(12);

      // Random latency, random ready, random redirects.
      p0 = npop;
      for (int s = 0; s < 6; s++) begin
         lat = $urandom_range(1, 3);
         rdy_pct = $urandom_range(40, 100);
         ir_pct = $urandom_range(50, 100);
         for (int i = 0; i < 50; i++) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            t = {22'h0, 8'($urandom_range(255)), 2'b00};
`else
            t = {22'h0, 8'($urandom_range(255)), 2'($urandom_range(3))};
`endif
            cycle($urandom_range(19) == 0, t);
         end
      end
      chk("random_progress", {31'h0, (npop - p0) >= 20}, 32'h1);

      // Asynchronous reset mid-stream with a full buffer.
      lat = 1; rdy_pct = 100; ir_pct = 0;
      run(6);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'h0, instr_valid}, 32'h0);
      chk("arst_pc", pc, 32'h0);
      chk("arst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      imem_rsp_valid = 1'b0;
      q_addr.delete(); q_due.delete();
      inflight = 0; exp_pc = 32'h0; exp_req = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      ir_pct = 100;
      run(4);
      chk("restart_valid", {31'h0, last_valid}, 32'h1);
      run(10);

`ifdef FETCH_MISALIGN_CHECK_EN
      cycle(1'b1, 32'h0000_0102);
      chk("fault_set", {31'h0, fetch_fault}, 32'h1);
      run(4);
      chk("fault_halt_req", {31'h0, last_req_valid}, 32'h0);
      chk("fault_halt_valid", {31'h0, last_valid}, 32'h0);
      cycle(1'b1, 32'h0000_0200);
      chk("fault_clear", {31'h0, fetch_fault}, 32'h0);
      run(3);
      chk("resume_pc", last_pc, 32'h0000_0200);
      run(6);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
